// File: rtl/sub_pkg.sv
// Shared definitions for the serial arithmetic family: FSM state encodings
// and the two's-complement overflow helper used when a result is finalised.
package sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_e;

  // Signed overflow of a - b, judged from the operand and result sign bits.
  function automatic logic signed_sub_ovf(input logic a_msb,
                                          input logic b_msb,
                                          input logic d_msb);
    return (a_msb ^ b_msb) & (a_msb ^ d_msb);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit subtractor cell: difference and borrow-out of a - b - bin.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B: operands shift out LSB-first through one full_subtractor,
// the difference shifts into Result from the MSB side; Width edges per operation.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  output logic             Ready,
  output logic             Done,
  output logic [Width-1:0] Result,
  output logic             Bout,
  output logic             Ovf
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [CntW-1:0] LastBit = CntW'(Width - 1);

  sub_state_e       state_q, state_d;
  logic [Width-1:0] a_q, a_d;
  logic [Width-1:0] b_q, b_d;
  logic [Width-1:0] res_q, res_d;
  logic             bw_q, bw_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             cell_d;
  logic             cell_bout;

  full_subtractor u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bw_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // State register and datapath flops.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      bw_q    <= 1'b0;
      cnt_q   <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      bw_q    <= bw_d;
      cnt_q   <= cnt_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    bw_d    = bw_q;
    cnt_d   = cnt_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          bw_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d   = {1'b0, a_q[Width-1:1]};
        b_d   = {1'b0, b_q[Width-1:1]};
        res_d = {cell_d, res_q[Width-1:1]};
        bw_d  = cell_bout;
        // On the last bit the shifted-out operand bits are the captured sign bits.
        if (cnt_q == LastBit) begin
          bout_d  = cell_bout;
          ovf_d   = signed_sub_ovf(a_q[0], b_q[0], cell_d);
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign Ready  = (state_q == ST_IDLE);
  assign Done   = (state_q == ST_DONE);
  assign Result = res_q;
  assign Bout   = bout_q;
  assign Ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at Width=16: expected results are
// queued when a request is driven and compared whenever Done pulses.
module tb_serial_subtractor;

  localparam int W = 16;

  logic         Clock = 1'b0;
  logic         Reset_n;
  logic         Start;
  logic [W-1:0] A, B;
  logic         Ready, Done, Bout, Ovf;
  logic [W-1:0] Result;

  typedef struct packed {
    logic [W-1:0] res;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   done_cnt = 0;
  int   done_cyc[$];

  serial_subtractor #(.Width(W)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Start   (Start),
    .A       (A),
    .B       (B),
    .Ready   (Ready),
    .Done    (Done),
    .Result  (Result),
    .Bout    (Bout),
    .Ovf     (Ovf)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.res  = a - b;
    e.bout = (a < b);
    e.ovf  = (a[W-1] ^ b[W-1]) & (a[W-1] ^ e.res[W-1]);
    return e;
  endfunction

  // Scoreboard monitor: every Done pulse consumes one expected entry.
  always @(negedge Clock) begin
    exp_t e;
    cyc++;
    if (Done === 1'b1) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      check_eq("done_has_expect", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("result", 64'(Result), 64'(e.res));
        check_eq("bout", 64'(Bout), 64'(e.bout));
        check_eq("ovf", 64'(Ovf), 64'(e.ovf));
      end
    end
  end

  // Single request, one-cycle Start; checks latency, Ready return and output hold.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int   n;
    exp_t e;
    e = ref_model(a, b);
    A = a;
    B = b;
    Start = 1'b1;
    sb_q.push_back(e);
    @(negedge Clock);
    Start = 1'b0;
    A = ~a;
    B = ~b;
    n = 1;
    while (Done !== 1'b1 && n < 40) begin
      @(negedge Clock);
      n++;
    end
    check_eq({tag, "_latency"}, 64'(n), 64'(W + 1));
    @(negedge Clock);
    check_eq({tag, "_ready"}, 64'(Ready), 64'd1);
    @(negedge Clock);
    check_eq({tag, "_hold"}, 64'(Result), 64'(e.res));
  endtask

  initial begin
    int d0;
    int n;
    logic [W-1:0] ra, rb;
    Reset_n = 1'b0;
    Start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge Clock);
    check_eq("rst_ready", 64'(Ready), 64'd1);
    check_eq("rst_done", 64'(Done), 64'd0);
    check_eq("rst_result", 64'(Result), 64'd0);
    check_eq("rst_bout", 64'(Bout), 64'd0);
    check_eq("rst_ovf", 64'(Ovf), 64'd0);
    Reset_n = 1'b1;

    run_op(16'h0005, 16'h0003, "sub_5_3");
    run_op(16'h0000, 16'h0001, "sub_0_1");
    run_op(16'h8000, 16'h0001, "sub_min_1");
    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, "rand");
    end
    run_op(16'h7FFF, 16'hFFFF, "sub_max_neg1");

    // Abort mid-run: outputs clear asynchronously and no Done follows.
    A = 16'hAAAA;
    B = 16'h5555;
    Start = 1'b1;
    sb_q.push_back(ref_model(16'hAAAA, 16'h5555));
    @(negedge Clock);
    Start = 1'b0;
    repeat (8) @(negedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    check_eq("abort_ready", 64'(Ready), 64'd1);
    check_eq("abort_done", 64'(Done), 64'd0);
    check_eq("abort_result", 64'(Result), 64'd0);
    check_eq("abort_bout", 64'(Bout), 64'd0);
    check_eq("abort_ovf", 64'(Ovf), 64'd0);
    sb_q.delete();
    d0 = done_cnt;
    @(negedge Clock);
    Reset_n = 1'b1;
    repeat (25) @(negedge Clock);
    check_eq("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run_op(16'h1234, 16'h0234, "post_reset");

    // Start pulses during RUN must not disturb the operation in flight.
    d0 = done_cnt;
    A = 16'h0010;
    B = 16'h0001;
    Start = 1'b1;
    sb_q.push_back(ref_model(16'h0010, 16'h0001));
    @(negedge Clock);
    A = 16'hFFFF;
    B = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      Start = ~Start;
      @(negedge Clock);
    end
    Start = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 40) begin
      @(negedge Clock);
      n++;
    end
    repeat (25) @(negedge Clock);
    check_eq("inflight_single_done", 64'(done_cnt - d0), 64'd1);

    // Start held high across three back-to-back operations.
    done_cyc.delete();
    A = 16'h1111;
    B = 16'h2222;
    Start = 1'b1;
    sb_q.push_back(ref_model(16'h1111, 16'h2222));
    @(negedge Clock);
    A = 16'hBEEF;
    B = 16'h0EEF;
    sb_q.push_back(ref_model(16'hBEEF, 16'h0EEF));
    repeat (W + 2) @(negedge Clock);
    A = 16'h8001;
    B = 16'h7FFF;
    sb_q.push_back(ref_model(16'h8001, 16'h7FFF));
    repeat (W + 2) @(negedge Clock);
    Start = 1'b0;
    n = 0;
    while (done_cyc.size() < 3 && n < 60) begin
      @(negedge Clock);
      n++;
    end
    repeat (3) @(negedge Clock);
    check_eq("b2b_count", 64'(done_cyc.size()), 64'd3);
    if (done_cyc.size() >= 3) begin
      check_eq("b2b_gap1", 64'(done_cyc[1] - done_cyc[0]), 64'(W + 2));
      check_eq("b2b_gap2", 64'(done_cyc[2] - done_cyc[1]), 64'(W + 2));
    end
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
